// File: rtl/fft_output_reorder_pkg.sv
// Shared FFT helpers: address-width computation and bit-reversal used by the
// SDF chain and the output reorder buffer.
package fft_output_reorder_pkg;

    localparam int MIN_POINTS = 4;

    // Ceiling log2, identical to the one used to size the SDF stage counters.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Reverse the low 'width' bits of value; bits above width come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                result[i] = value[width-1-i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_output_reorder_pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one registered read port.
// The address MSB selects the bank, so the two halves act as the ping-pong pair.
module pingpong_ram
    import fft_output_reorder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [log2(DEPTH)-1:0]   wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [log2(DEPTH)-1:0]   rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its value when idle so the output stays stable.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_output_reorder.sv
// Reorders each bit-reversed N-point SDF output frame into natural order using
// a ping-pong buffer: one bank fills while the other drains.
module fft_output_reorder
    import fft_output_reorder_pkg::*;
#(
    parameter int N     = 128,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int L  = log2(N);
    localparam int AW = L + 1;
    localparam int DW = 2 * WIDTH;
    localparam logic [L-1:0] LAST = L'(N - 1);

    logic [L-1:0]  wr_cnt_q;
    logic          wr_bank_q;
    logic          rd_active_q;
    logic [L-1:0]  rd_cnt_q;
    logic          rd_bank_q;
    logic          do_en_q;
    logic          have_data_q;

    logic          frame_done;
    logic [L-1:0]  wr_rev;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    assign frame_done = di_en && (wr_cnt_q == LAST);
    assign wr_rev     = L'(bitrev(32'(wr_cnt_q), L));
    assign wr_addr    = {wr_bank_q, wr_rev};
    assign rd_addr    = {rd_bank_q, rd_cnt_q};
    assign wr_data    = {di_re, di_im};

    // Write side: a drop of di_en discards the partial frame without a swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (di_en) begin
            wr_cnt_q <= wr_cnt_q + L'(1);
            if (frame_done) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end else begin
            wr_cnt_q <= '0;
        end
    end

    // Read side: a completing frame reloads the reader even on its last sample,
    // which is what keeps back-to-back frames gap-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_active_q <= 1'b0;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
        end else if (frame_done) begin
            rd_active_q <= 1'b1;
            rd_cnt_q    <= '0;
            rd_bank_q   <= wr_bank_q;
        end else if (rd_active_q) begin
            rd_cnt_q <= rd_cnt_q + L'(1);
            if (rd_cnt_q == LAST) begin
                rd_active_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_en_q     <= 1'b0;
            have_data_q <= 1'b0;
        end else begin
            do_en_q <= rd_active_q;
            if (rd_active_q) begin
                have_data_q <= 1'b1;
            end
        end
    end

    pingpong_ram #(
        .DEPTH (2 * N),
        .WIDTH (DW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (di_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_active_q),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // The RAM read register has no reset, so data is masked to zero until the
    // first read after reset; afterwards it holds the last sample.
    assign do_en = do_en_q;
    assign do_re = have_data_q ? rd_data[DW-1:WIDTH] : '0;
    assign do_im = have_data_q ? rd_data[WIDTH-1:0]  : '0;

endmodule
